motor_drive_ramp: RTL and testbench

//  Consumes the 3-bit direction code from the waiter direction FSM. Drives the
//  two DC-motor H-bridge channels with soft-start/soft-stop PWM.

---
 rtl/motor_pkg.sv | 35 +++
 rtl/pwm_gen.sv | 55 +++++
 rtl/motor_drive_ramp.sv | 158 +++++++++++++++
 tb/tb_motor_drive_ramp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared command codes, drive FSM states and direction helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package motor_pkg;

    // Codes produced by the upstream waiter direction FSM.
    typedef enum logic [2:0] {
        DIR_IDLE_BASE  = 3'b000,
        DIR_FORWARDS   = 3'b001,
        DIR_IDLE_TABLE = 3'b010,
        DIR_BACKWARDS  = 3'b011,
        DIR_STOP       = 3'b100
    } direction_t;

    typedef enum logic [1:0] {IDLE, DRIVE, BRAKE, DEAD} drive_state_t;

    typedef enum logic {DIR_FWD, DIR_REV} drive_dir_t;

    // Internal command after decode; unused and idle codes all collapse to HALT.
    typedef enum logic [1:0] {CMD_HALT, CMD_FWD, CMD_REV, CMD_ESTOP} cmd_t;

    function automatic cmd_t decode_cmd(input logic [2:0] code);
        case (code)
            DIR_FORWARDS:  return CMD_FWD;
            DIR_BACKWARDS: return CMD_REV;
            DIR_STOP:      return CMD_ESTOP;
            default:       return CMD_HALT;
        endcase
    endfunction

    function automatic cmd_t dir_to_cmd(input drive_dir_t dir);
        return (dir == DIR_REV) ? CMD_REV : CMD_FWD;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: 255-step PWM with a glitch-free, period-boundary duty latch.
// Latency: duty_in takes effect from step 0 of the next PWM period; force_zero clears duty_now on the next edge.
// Backpressure: none, free-running from reset.
// Ports: clk, reset (async, active-high), duty_in[7:0] requested duty,
//        force_zero (emergency cut), pwm_en (PWM output), duty_now[7:0] (applied duty).
module pwm_gen
#(
    parameter int PWM_DIV = 50
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty_in,
    input  logic       force_zero,
    output logic       pwm_en,
    output logic [7:0] duty_now
);
    localparam int               PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);
    localparam logic [7:0]       CNT_MAX = 8'd254;

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_duty_now;
    logic             w_pre_wrap;
    logic             w_cnt_wrap;

    assign w_pre_wrap = (r_pre == PRE_MAX);
    assign w_cnt_wrap = w_pre_wrap && (r_pwm_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre      <= '0;
            r_pwm_cnt  <= '0;
            r_duty_now <= '0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
            if (w_pre_wrap) begin
                r_pwm_cnt <= (r_pwm_cnt == CNT_MAX) ? 8'd0 : r_pwm_cnt + 8'd1;
            end
            // Emergency cut beats the boundary latch; otherwise duty only
            // changes as the counter wraps so no period is ever truncated.
            if (force_zero) begin
                r_duty_now <= '0;
            end else if (w_cnt_wrap) begin
                r_duty_now <= duty_in;
            end
        end
    end

    // Counter never exceeds 254, so duty 255 yields a constant high.
    assign pwm_en   = (r_pwm_cnt < r_duty_now);
    assign duty_now = r_duty_now;

endmodule

// File: rtl/motor_drive_ramp.sv
// motor_drive_ramp: H-bridge driver with soft-start/soft-stop ramps, dead time before energise/reversal, emergency cut.
// Latency: reacts on the first edge after a direction change; duty moves 1 LSB per ramp tick, applied at PWM period boundaries.
// Backpressure: none; busy flags BRAKE/DEAD so the caller can see a transition in progress.
// Ports: clk, reset (async, active-high), direction[2:0], target_duty[7:0],
//        left_in1/left_in2/right_in1/right_in2 bridge pins, pwm_en shared enable,
//        duty_now[7:0] applied duty, busy (BRAKE or DEAD).
module motor_drive_ramp
    import motor_pkg::*;
#(
    parameter int PWM_DIV          = 50,
    parameter int RAMP_TICK_CYCLES = 500000,
    parameter int DEAD_CYCLES      = 5000000,
    parameter int RIGHT_INVERT     = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] direction,
    input  logic [7:0] target_duty,
    output logic       left_in1,
    output logic       left_in2,
    output logic       right_in1,
    output logic       right_in2,
    output logic       pwm_en,
    output logic [7:0] duty_now,
    output logic       busy
);
    localparam int                RAMP_W   = (RAMP_TICK_CYCLES > 1) ? $clog2(RAMP_TICK_CYCLES) : 1;
    localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_TICK_CYCLES - 1);
    localparam int                DEAD_W   = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES - 1);

    drive_state_t      r_state;
    drive_dir_t        r_drive_dir;
    logic [7:0]        r_duty_reg;
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;

    cmd_t       w_cmd;
    drive_dir_t w_cmd_dir;
    logic       w_is_drive;
    logic       w_same;
    logic       w_estop;
    logic       w_ramp_tick;
    logic [7:0] w_duty_step;
    logic       w_energise;
    logic       w_fwd;
    logic       w_rev;

    assign w_cmd       = decode_cmd(direction);
    assign w_is_drive  = (w_cmd == CMD_FWD) || (w_cmd == CMD_REV);
    assign w_cmd_dir   = (w_cmd == CMD_REV) ? DIR_REV : DIR_FWD;
    assign w_same      = (w_cmd == dir_to_cmd(r_drive_dir));
    assign w_ramp_tick = (r_ramp_cnt == RAMP_MAX);
    // Only an energised bridge needs the cut. DEAD is already de-energised
    // with zero duty, and must keep counting so a held STOP can reach IDLE.
    assign w_estop     = (w_cmd == CMD_ESTOP) && ((r_state == DRIVE) || (r_state == BRAKE));

    // One LSB toward target, saturating on arrival.
    always_comb begin
        w_duty_step = r_duty_reg;
        if (r_duty_reg < target_duty) begin
            w_duty_step = r_duty_reg + 8'd1;
        end else if (r_duty_reg > target_duty) begin
            w_duty_step = r_duty_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drive_dir <= DIR_FWD;
            r_duty_reg  <= '0;
            r_ramp_cnt  <= '0;
            r_dead_cnt  <= '0;
        end else begin
            r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
            if (w_estop) begin
                r_state    <= DEAD;
                r_duty_reg <= '0;
                r_dead_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_duty_reg <= '0;
                        if (w_is_drive) begin
                            r_drive_dir <= w_cmd_dir;
                            r_dead_cnt  <= '0;
                            r_state     <= DEAD;
                        end
                    end
                    DEAD: begin
                        r_duty_reg <= '0;
                        if (r_dead_cnt == DEAD_MAX) begin
                            r_dead_cnt <= '0;
                            if (w_same) begin
                                r_state <= DRIVE;
                            end else if (w_is_drive) begin
                                // Direction flipped during the gap: a full gap
                                // is owed for the new polarity.
                                r_drive_dir <= w_cmd_dir;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_dead_cnt <= r_dead_cnt + 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (!w_same) begin
                            r_state <= BRAKE;
                        end else if (w_ramp_tick) begin
                            r_duty_reg <= w_duty_step;
                        end
                    end
                    BRAKE: begin
                        // Wait for the PWM latch too, so polarity never drops
                        // while a non-zero duty is still being applied.
                        if ((r_duty_reg == 8'd0) && (duty_now == 8'd0)) begin
                            r_state    <= DEAD;
                            r_dead_cnt <= '0;
                            if (w_is_drive) begin
                                r_drive_dir <= w_cmd_dir;
                            end
                        end else if (w_ramp_tick && (r_duty_reg != 8'd0)) begin
                            r_duty_reg <= r_duty_reg - 8'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm (
        .clk        (clk),
        .reset      (reset),
        .duty_in    (r_duty_reg),
        .force_zero (w_estop),
        .pwm_en     (pwm_en),
        .duty_now   (duty_now)
    );

    // drive_dir only changes in IDLE/DEAD where the bridge is off, so this
    // decode cannot produce an in1/in2 overlap.
    assign w_energise = (r_state == DRIVE) || (r_state == BRAKE);
    assign w_fwd      = w_energise && (r_drive_dir == DIR_FWD);
    assign w_rev      = w_energise && (r_drive_dir == DIR_REV);

    assign left_in1   = w_fwd;
    assign left_in2   = w_rev;
    assign right_in1  = (RIGHT_INVERT != 0) ? w_rev : w_fwd;
    assign right_in2  = (RIGHT_INVERT != 0) ? w_fwd : w_rev;
    assign busy       = (r_state == BRAKE) || (r_state == DEAD);

endmodule

// File: tb/tb_motor_drive_ramp.sv
// tb_motor_drive_ramp: self-checking bench for motor_drive_ramp with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_motor_drive_ramp;

    logic       clk;
    logic       reset;
    logic [2:0] direction;
    logic [7:0] target_duty;
    logic       left_in1, left_in2, right_in1, right_in2;
    logic       pwm_en;
    logic [7:0] duty_now;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int shoot_thru = 0;
    int map_bad    = 0;

    typedef struct {
        logic [7:0] target;
        logic [7:0] exp_duty;
        int         exp_high;
    } vec_t;

    vec_t tbl [4];
    vec_t sb_q [$];

    motor_drive_ramp #(
        .PWM_DIV          (1),
        .RAMP_TICK_CYCLES (4),
        .DEAD_CYCLES      (8),
        .RIGHT_INVERT     (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .direction   (direction),
        .target_duty (target_duty),
        .left_in1    (left_in1),
        .left_in2    (left_in2),
        .right_in1   (right_in1),
        .right_in2   (right_in2),
        .pwm_en      (pwm_en),
        .duty_now    (duty_now),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shoot-through and mirror-mounting checks on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if ((left_in1 && left_in2) || (right_in1 && right_in2)) shoot_thru++;
            if ((right_in1 !== left_in2) || (right_in2 !== left_in1)) map_bad++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic pins_low();
        return !(left_in1 | left_in2 | right_in1 | right_in2);
    endfunction

    task automatic wait_duty(input logic [7:0] v, input int budget, input string nm);
        int n = 0;
        while (duty_now !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, duty_now, v);
    endtask

    task automatic wait_pins_low(input int budget, input string nm);
        int n = 0;
        while (!pins_low() && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, pins_low(), 1);
    endtask

    // Counts consecutive de-energised busy samples starting at the current one.
    task automatic count_dead(output int n);
        n = 0;
        while (busy && pins_low() && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (255) begin
            @(negedge clk);
            if (pwm_en) n++;
        end
    endtask

    // Returns with the current sample being the first high after a low.
    task automatic wait_rise(input int budget, input string nm);
        logic prev;
        int   n = 0;
        prev = pwm_en;
        @(negedge clk);
        while (!(!prev && pwm_en) && n < budget) begin
            prev = pwm_en;
            @(negedge clk);
            n++;
        end
        chk(nm, {prev, pwm_en}, 2'b01);
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] last;
        vec_t exp;

        tbl[0] = '{target: 8'd0,   exp_duty: 8'd0,   exp_high: 0};
        tbl[1] = '{target: 8'd128, exp_duty: 8'd128, exp_high: 128};
        tbl[2] = '{target: 8'd255, exp_duty: 8'd255, exp_high: 255};
        tbl[3] = '{target: 8'd37,  exp_duty: 8'd37,  exp_high: 37};

        // Reset state
        reset = 1'b1; direction = 3'b000; target_duty = 8'd0;
        #1;
        chk("rst_pins", {left_in1, left_in2, right_in1, right_in2}, 4'b0000);
        chk("rst_pwm_en", pwm_en, 0);
        chk("rst_duty_now", duty_now, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Forward start: dead gap then ramp
        direction = 3'b001; target_duty = 8'd10;
        @(negedge clk);
        chk("fwd_dead_busy", busy, 1);
        count_dead(n);
        chk("fwd_dead_len", n, 8);
        chk("fwd_pins", {left_in1, left_in2, right_in1, right_in2}, 4'b1001);
        chk("fwd_busy", busy, 0);
        wait_duty(8'd10, 600, "fwd_duty10");
        count_high(n);
        chk("fwd_high10", n, 10);

        // Reversal: hold FWD through brake, dead gap, then REV
        direction = 3'b011;
        @(negedge clk);
        chk("rev_brake_busy", busy, 1);
        bad = 0; n = 0;
        while (!pins_low() && n < 600) begin
            if (!(left_in1 && !left_in2)) bad++;
            @(negedge clk);
            n++;
        end
        chk("rev_brake_reached_dead", pins_low(), 1);
        chk("rev_brake_pins_fwd", bad, 0);
        chk("rev_dead_duty0", duty_now, 0);
        count_dead(n);
        chk("rev_dead_len", n, 8);
        chk("rev_pins", {left_in1, left_in2, right_in1, right_in2}, 4'b0110);
        wait_duty(8'd10, 600, "rev_duty10");

        // Emergency stop
        direction = 3'b100;
        @(negedge clk);
        chk("estop_pins", pins_low(), 1);
        chk("estop_duty_now", duty_now, 0);
        chk("estop_pwm_en", pwm_en, 0);
        count_dead(n);
        chk("estop_dead_len", n, 8);
        bad = 0;
        repeat (20) begin
            if (busy || !pins_low()) bad++;
            @(negedge clk);
        end
        chk("estop_hold_idle", bad, 0);

        // Undefined code 111 behaves as HALT
        direction = 3'b001;
        @(negedge clk);
        count_dead(n);
        wait_duty(8'd10, 600, "halt_pre_duty10");
        direction = 3'b111;
        @(negedge clk);
        chk("halt_brake", {busy, left_in1}, 2'b11);
        wait_pins_low(600, "halt_reach_dead");
        chk("halt_dead_duty0", duty_now, 0);
        count_dead(n);
        chk("halt_dead_len", n, 8);
        chk("halt_idle", {busy, pins_low()}, 2'b01);

        // Re-request forward mid-brake: no re-ramp until the gap completes
        direction = 3'b001;
        @(negedge clk);
        count_dead(n);
        wait_duty(8'd10, 600, "mid_pre_duty10");
        direction = 3'b111;
        repeat (6) @(negedge clk);
        direction = 3'b001;
        bad = 0; n = 0; last = duty_now;
        while (!pins_low() && n < 600) begin
            if (duty_now > last || !left_in1) bad++;
            last = duty_now;
            @(negedge clk);
            n++;
        end
        chk("mid_brake_no_reramp", bad, 0);
        chk("mid_brake_reached_dead", pins_low(), 1);
        count_dead(n);
        chk("mid_dead_len", n, 8);
        chk("mid_fwd_again", left_in1, 1);

        // PWM duty table through the scoreboard
        for (int i = 0; i < 4; i++) begin
            target_duty = tbl[i].target;
            sb_q.push_back(tbl[i]);
            wait_duty(tbl[i].target, 2000, "tbl_settle");
            count_high(n);
            exp = sb_q.pop_front();
            chk("tbl_duty_now", duty_now, exp.exp_duty);
            chk("tbl_high_cycles", n, exp.exp_high);
        end
        chk("sb_empty", sb_q.size(), 0);

        // Target change mid-period takes effect only at the next period
        wait_rise(600, "mp_rise1");
        target_duty = 8'd20;
        bad = 0;
        repeat (250) begin
            @(negedge clk);
            if (duty_now !== 8'd37) bad++;
        end
        chk("mp_hold_old", bad, 0);
        wait_rise(300, "mp_rise2");
        chk("mp_new_duty", duty_now, 20);

        // Asynchronous reset mid-drive
        target_duty = 8'd10;
        wait_duty(8'd10, 600, "ar_duty10");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pins", {left_in1, left_in2, right_in1, right_in2}, 4'b0000);
        chk("ar_pwm_en", pwm_en, 0);
        chk("ar_duty_now", duty_now, 0);
        chk("ar_busy", busy, 0);
        direction = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("ar_idle", {busy, pins_low()}, 2'b01);

        chk("no_shoot_through", shoot_thru, 0);
        chk("right_mirror_map", map_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
